// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU encodings, FSM states and control bundle
package ctrl_pkg;

    // Opcode field instr[6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // ALU operation classes
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_LUI    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Control bundle, MSB first
    typedef struct packed {
        logic       branch;
        logic       mem_rd;
        logic       mem_to_reg;
        logic       mem_wr;
        logic       a_sel;
        logic       b_sel;
        logic       reg_wr;
        logic       jump;
        logic       pc_to_reg;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// rtl/ctrl_pipe_unit_decode.sv - combinational opcode to control bundle decoder
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode_i,
    output ctrl_bundle_t bundle_o,
    output logic         legal_o,
    output logic         is_system_o
);

    // Opcode lookup; unknown opcodes yield a NOP bundle and legal_o=0
    always_comb begin
        bundle_o    = CTRL_NOP;
        legal_o     = 1'b1;
        is_system_o = 1'b0;
        case (opcode_i)
            OP_R: begin
                bundle_o.alu_op = ALU_FUNCT;
                bundle_o.reg_wr = 1'b1;
            end
            OP_I: begin
                bundle_o.alu_op = ALU_FUNCT;
                bundle_o.b_sel  = 1'b1;
                bundle_o.reg_wr = 1'b1;
            end
            OP_LOAD: begin
                bundle_o.mem_rd     = 1'b1;
                bundle_o.mem_to_reg = 1'b1;
                bundle_o.b_sel      = 1'b1;
                bundle_o.reg_wr     = 1'b1;
            end
            OP_STORE: begin
                bundle_o.mem_wr = 1'b1;
                bundle_o.b_sel  = 1'b1;
            end
            OP_BRANCH: begin
                bundle_o.branch = 1'b1;
                bundle_o.alu_op = ALU_BRANCH;
            end
            OP_LUI: begin
                bundle_o.alu_op = ALU_LUI;
                bundle_o.b_sel  = 1'b1;
                bundle_o.reg_wr = 1'b1;
            end
            OP_AUIPC: begin
                bundle_o.a_sel  = 1'b1;
                bundle_o.b_sel  = 1'b1;
                bundle_o.reg_wr = 1'b1;
            end
            OP_JAL: begin
                bundle_o.jump      = 1'b1;
                bundle_o.reg_wr    = 1'b1;
                bundle_o.pc_to_reg = 1'b1;
                bundle_o.a_sel     = 1'b1;
                bundle_o.b_sel     = 1'b1;
            end
            OP_JALR: begin
                bundle_o.jump      = 1'b1;
                bundle_o.reg_wr    = 1'b1;
                bundle_o.pc_to_reg = 1'b1;
                bundle_o.b_sel     = 1'b1;
            end
            OP_FENCE:  ;
            OP_SYSTEM: is_system_o = 1'b1;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - registered decode into ID/EX with stall/flush and SYSTEM halt FSM
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned ALU_OP_W     = 2,
    parameter int unsigned SYS_MODE     = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    input  logic [4:0]          opcode_i,
    input  logic                sys_ebreak_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                resume_i,
    output logic                pc_wr_en_o,
    output logic                ex_valid_o,
    output logic                ex_branch_o,
    output logic                ex_mem_rd_o,
    output logic                ex_mem_to_reg_o,
    output logic                ex_mem_wr_o,
    output logic                ex_a_sel_o,
    output logic                ex_b_sel_o,
    output logic                ex_reg_wr_o,
    output logic                ex_jump_o,
    output logic                ex_pc_to_reg_o,
    output logic [ALU_OP_W-1:0] ex_alu_op_o,
    output logic                halted_o,
    output logic                illegal_o,
    output logic                illegal_seen_o
);

    localparam int CNT_W = 4;

    ctrl_bundle_t dec_bundle;
    logic         dec_legal;
    logic         dec_is_system;

    state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_bundle_t ex_q, ex_d;
    logic         ex_valid_q, ex_valid_d;
    logic         illegal_q, illegal_d;
    logic         illegal_seen_q, illegal_seen_d;

    logic         in_run;
    logic         accept;
    logic         halt_req;
    logic         flush_eff;

    ctrl_decode u_decode (
        .opcode_i    (opcode_i),
        .bundle_o    (dec_bundle),
        .legal_o     (dec_legal),
        .is_system_o (dec_is_system)
    );

    assign in_run   = (state_q == ST_RUN);
    assign accept   = instr_valid_i & ~stall_i & ~flush_i & in_run;
    assign halt_req = accept & dec_legal & dec_is_system &
                      ((SYS_MODE == 0) || sys_ebreak_i);
    // The halting SYSTEM has already passed the flush point while draining
    assign flush_eff = flush_i & (state_q != ST_DRAIN);

    // Halt FSM next-state and drain counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (!stall_i) begin
                    if (cnt_q == '0) begin
                        state_d = ST_HALT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ID/EX next-state: flush, then stall, then accepted legal decode, else bubble
    always_comb begin
        ex_d           = ex_q;
        ex_valid_d     = ex_valid_q;
        illegal_d      = accept & ~dec_legal;
        illegal_seen_d = illegal_seen_q | (accept & ~dec_legal);
        if (flush_eff) begin
            ex_d       = CTRL_NOP;
            ex_valid_d = 1'b0;
        end else if (stall_i) begin
            ex_d       = ex_q;
            ex_valid_d = ex_valid_q;
        end else if (accept && dec_legal) begin
            ex_d       = dec_bundle;
            ex_valid_d = 1'b1;
        end else begin
            ex_d       = CTRL_NOP;
            ex_valid_d = 1'b0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            ex_q           <= CTRL_NOP;
            ex_valid_q     <= 1'b0;
            illegal_q      <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ex_q           <= ex_d;
            ex_valid_q     <= ex_valid_d;
            illegal_q      <= illegal_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign pc_wr_en_o      = rst_i | (in_run & ~halt_req);
    assign ex_valid_o      = ex_valid_q;
    assign ex_branch_o     = ex_q.branch;
    assign ex_mem_rd_o     = ex_q.mem_rd;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign ex_mem_wr_o     = ex_q.mem_wr;
    assign ex_a_sel_o      = ex_q.a_sel;
    assign ex_b_sel_o      = ex_q.b_sel;
    assign ex_reg_wr_o     = ex_q.reg_wr;
    assign ex_jump_o       = ex_q.jump;
    assign ex_pc_to_reg_o  = ex_q.pc_to_reg;
    assign ex_alu_op_o     = ALU_OP_W'(ex_q.alu_op);
    assign halted_o        = (state_q == ST_HALT);
    assign illegal_o       = illegal_q;
    assign illegal_seen_o  = illegal_seen_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - directed self-checking bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [4:0] op = 5'b0;
    logic       ebreak = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       resume = 1'b0;

    int checks = 0;
    int failures = 0;

    // dut0: SYS_MODE=0, dut1: SYS_MODE=1, both driven identically
    logic       pc0, vld0, br0, mrd0, m2r0, mwr0, as0, bs0, rw0, jmp0, p2r0, halt0, ill0, ills0;
    logic [1:0] alu0;
    logic       pc1, vld1, br1, mrd1, m2r1, mwr1, as1, bs1, rw1, jmp1, p2r1, halt1, ill1, ills1;
    logic [1:0] alu1;

    // Bundle view: {branch,mem_rd,mem_to_reg,mem_wr, a_sel,b_sel,reg_wr,jump, pc_to_reg,alu_op[1:0],valid}
    logic [11:0] v0, v1;
    assign v0 = {br0, mrd0, m2r0, mwr0, as0, bs0, rw0, jmp0, p2r0, alu0, vld0};
    assign v1 = {br1, mrd1, m2r1, mwr1, as1, bs1, rw1, jmp1, p2r1, alu1, vld1};

    localparam logic [11:0] E_R      = 12'b0000_0010_0101;
    localparam logic [11:0] E_LOAD   = 12'b0110_0110_0001;
    localparam logic [11:0] E_JAL    = 12'b0000_1111_1001;
    localparam logic [11:0] E_BRANCH = 12'b1000_0000_0011;
    localparam logic [11:0] E_NOP    = 12'b0000_0000_0001;
    localparam logic [11:0] E_BUB    = 12'b0000_0000_0000;

    localparam logic [4:0] O_R = 5'b01100, O_LOAD = 5'b00000, O_JAL = 5'b11011;
    localparam logic [4:0] O_BR = 5'b11000, O_SYS = 5'b11100, O_BAD = 5'b11111;

    ctrl_pipe_unit #(.DRAIN_CYCLES(3), .ALU_OP_W(2), .SYS_MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(valid), .opcode_i(op),
        .sys_ebreak_i(ebreak), .stall_i(stall), .flush_i(flush), .resume_i(resume),
        .pc_wr_en_o(pc0), .ex_valid_o(vld0), .ex_branch_o(br0), .ex_mem_rd_o(mrd0),
        .ex_mem_to_reg_o(m2r0), .ex_mem_wr_o(mwr0), .ex_a_sel_o(as0), .ex_b_sel_o(bs0),
        .ex_reg_wr_o(rw0), .ex_jump_o(jmp0), .ex_pc_to_reg_o(p2r0), .ex_alu_op_o(alu0),
        .halted_o(halt0), .illegal_o(ill0), .illegal_seen_o(ills0)
    );

    ctrl_pipe_unit #(.DRAIN_CYCLES(3), .ALU_OP_W(2), .SYS_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(valid), .opcode_i(op),
        .sys_ebreak_i(ebreak), .stall_i(stall), .flush_i(flush), .resume_i(resume),
        .pc_wr_en_o(pc1), .ex_valid_o(vld1), .ex_branch_o(br1), .ex_mem_rd_o(mrd1),
        .ex_mem_to_reg_o(m2r1), .ex_mem_wr_o(mwr1), .ex_a_sel_o(as1), .ex_b_sel_o(bs1),
        .ex_reg_wr_o(rw1), .ex_jump_o(jmp1), .ex_pc_to_reg_o(p2r1), .ex_alu_op_o(alu1),
        .halted_o(halt1), .illegal_o(ill1), .illegal_seen_o(ills1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic eb,
                         input logic st, input logic fl);
        valid  = v;
        op     = o;
        ebreak = eb;
        stall  = st;
        flush  = fl;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_bundle", v0, E_BUB);
        chk("rst_halted", halt0, 1'b0);
        chk("rst_illegal", ill0, 1'b0);
        chk("rst_ill_seen", ills0, 1'b0);
        chk("rst_pc_wr", pc0, 1'b1);
        tick();
        rst = 1'b0;

        // Back-to-back R, LOAD, JAL
        drive(1, O_R, 0, 0, 0);
        chk("run_pc_wr", pc0, 1'b1);
        tick(); chk("r_bundle", v0, E_R);
        drive(1, O_LOAD, 0, 0, 0);
        tick(); chk("load_bundle", v0, E_LOAD);
        drive(1, O_JAL, 0, 0, 0);
        tick(); chk("jal_bundle", v0, E_JAL);

        // LOAD then 2-cycle stall with BRANCH pending
        drive(1, O_LOAD, 0, 0, 0);
        tick(); chk("load2_bundle", v0, E_LOAD);
        drive(1, O_BR, 0, 1, 0);
        tick(); chk("stall1_hold", v0, E_LOAD);
        tick(); chk("stall2_hold", v0, E_LOAD);
        drive(1, O_BR, 0, 0, 0);
        tick(); chk("branch_bundle", v0, E_BRANCH);
        drive(1, O_R, 0, 1, 1);
        tick(); chk("flush_stall_bubble", v0, E_BUB);
        drive(0, O_R, 0, 0, 0);
        tick(); chk("novalid_bubble", v0, E_BUB);

        // ECALL: dut0 halts, dut1 treats as NOP
        drive(1, O_SYS, 0, 0, 0);
        chk("ecall_pc_wr0", pc0, 1'b0);
        chk("ecall_pc_wr1", pc1, 1'b1);
        tick();
        chk("ecall_nop0", v0, E_NOP);
        chk("ecall_nop1", v1, E_NOP);
        drive(0, O_R, 0, 0, 0);
        chk("drain_pc_wr0", pc0, 1'b0);
        chk("drain1_halted0", halt0, 1'b0);
        tick();
        chk("drain2_bubble0", v0, E_BUB);
        tick();
        chk("drain3_halted0", halt0, 1'b0);
        tick();
        chk("halt_halted0", halt0, 1'b1);
        chk("halt_pc_wr0", pc0, 1'b0);
        chk("ecall_halted1", halt1, 1'b0);
        chk("ecall_pc_wr1_later", pc1, 1'b1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        chk("resume_halted0", halt0, 1'b0);
        chk("resume_pc_wr0", pc0, 1'b1);

        // EBREAK with a stall during DRAIN
        drive(1, O_SYS, 1, 0, 0);
        chk("ebreak_pc_wr1", pc1, 1'b0);
        tick();
        chk("ebreak_nop1", v1, E_NOP);
        drive(0, O_R, 0, 1, 0);
        tick();
        chk("drain_stall_hold1", v1, E_NOP);
        drive(0, O_R, 0, 0, 0);
        tick();
        tick();
        chk("drain_extended1", halt1, 1'b0);
        tick();
        chk("ebreak_halted1", halt1, 1'b1);
        chk("ebreak_halted0", halt0, 1'b1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        chk("resume_halted1", halt1, 1'b0);

        // Illegal opcode
        drive(1, O_BAD, 0, 0, 0);
        tick();
        chk("illegal_bubble", v0, E_BUB);
        chk("illegal_pulse", ill0, 1'b1);
        chk("illegal_seen", ills0, 1'b1);
        drive(1, O_R, 0, 0, 0);
        tick();
        chk("illegal_pulse_end", ill0, 1'b0);
        chk("after_illegal_r", v0, E_R);
        tick();
        chk("illegal_seen_sticky", ills0, 1'b1);

        // SYSTEM squashed by flush
        drive(1, O_SYS, 0, 0, 1);
        chk("sys_flush_pc_wr", pc0, 1'b1);
        tick();
        chk("sys_flush_bubble", v0, E_BUB);
        drive(0, O_R, 0, 0, 0);
        tick(); tick(); tick(); tick();
        chk("sys_flush_no_halt", halt0, 1'b0);
        chk("sys_flush_pc_wr_later", pc0, 1'b1);

        // Halt again, then asynchronous reset in HALT
        drive(1, O_SYS, 0, 0, 0);
        tick();
        drive(0, O_R, 0, 0, 0);
        tick(); tick(); tick();
        chk("halt_again", halt0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_halted", halt0, 1'b0);
        chk("async_rst_bundle", v0, E_BUB);
        chk("async_rst_ill_seen", ills0, 1'b0);
        chk("async_rst_pc_wr", pc0, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_halted", halt0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Second-generation control unit. Decodes the 5-bit opcode (instr[6:2]) into the control bundle and registers it into the ID/EX stage, with a valid bit, stall/flush handling and illegal-opcode detection. It also contains a SYSTEM halt state machine: it freezes the PC, drains a parametrised number of cycles, then holds HALT until resume. It sits between the IF/ID register and the ID/EX register and replaces the purely combinational decoder.

Parameters:
DRAIN_CYCLES, 3, cycles to wait after a halting SYSTEM before entering HALT (legal range 1..15)
ALU_OP_W, 2, width of the alu_op field
SYS_MODE, 0, 0 = any SYSTEM halts; 1 = only EBREAK halts (ECALL becomes a NOP)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
instr_valid_i  in  1  IF/ID holds a valid instruction
opcode_i  in  5  instr[6:2]
sys_ebreak_i  in  1  instr[20]; 1 = EBREAK, 0 = ECALL (meaningful only for SYSTEM)
stall_i  in  1  hold ID/EX contents (load-use hazard)
flush_i  in  1  squash the ID slot (taken branch or jump in EX)
resume_i  in  1  leave HALT
pc_wr_en_o  out  1  PC write enable (combinational)
ex_valid_o  out  1  ID/EX slot valid
ex_branch_o, ex_mem_rd_o, ex_mem_to_reg_o, ex_mem_wr_o, ex_a_sel_o, ex_b_sel_o, ex_reg_wr_o, ex_jump_o, ex_pc_to_reg_o  out  1 each  registered control bits
ex_alu_op_o  out  ALU_OP_W  registered ALU op
halted_o  out  1  FSM in HALT
illegal_o  out  1  one-cycle pulse, registered
illegal_seen_o  out  1  sticky illegal flag

Behaviour:
- Reset (async, rst_i=1): all ex_* = 0, ex_valid_o = 0, illegal_o = 0, illegal_seen_o = 0, FSM = RUN, drain counter = 0. pc_wr_en_o is 1 during reset.
- Decode table (opcode -> asserted bits; alu_op 00 = add, 01 = branch compare, 10 = funct decode, 11 = LUI pass):
  - R 01100: alu 10, reg_wr
  - I 00100: alu 10, b_sel, reg_wr
  - LOAD 00000: mem_rd, mem_to_reg, b_sel, reg_wr
  - STORE 01000: mem_wr, b_sel
  - BRANCH 11000: branch, alu 01
  - LUI 01101: alu 11, b_sel, reg_wr
  - AUIPC 00101: a_sel, b_sel, reg_wr
  - JAL 11011: jump, reg_wr, pc_to_reg, a_sel, b_sel
  - JALR 11001: jump, reg_wr, pc_to_reg, b_sel
  - FENCE 00011: legal NOP
  - SYSTEM 11100: NOP bundle
  - any other opcode: illegal
- Accept condition: accept = instr_valid_i & ~stall_i & ~flush_i & (state==RUN).
- Latency: 1 cycle from IF/ID to the ex_* outputs.
- Register update priority, highest first:
  - flush_i: next cycle ex_valid_o=0 and all ex_* = 0 (bubble). Flush beats stall.
  - stall_i: hold all ex_* values.
  - accept & legal: load the decoded bundle, ex_valid_o=1.
  - otherwise: bubble.
- Illegal opcode on accept: bubble is loaded, illegal_o pulses 1 the next cycle, illegal_seen_o sets and stays set until reset.
- Halting SYSTEM: an accepted SYSTEM opcode with SYS_MODE==0, or with SYS_MODE==1 and sys_ebreak_i=1.
  - The SYSTEM instruction itself enters EX as a valid NOP.
  - With SYS_MODE==1 an ECALL is an ordinary valid NOP.
- FSM states RUN, DRAIN, HALT:
  - RUN -> DRAIN on an accepted halting SYSTEM; counter loads DRAIN_CYCLES-1.
  - DRAIN: counter decrements on each cycle with stall_i=0. At count 0 with stall_i=0, go to HALT. flush_i is ignored (the SYSTEM is already past the flush point). Nothing is accepted; bubbles are issued unless stalled.
  - HALT: halted_o=1; bubbles issued. resume_i=1 -> RUN next cycle.
  - resume_i is ignored outside HALT.
- pc_wr_en_o = 0 when state is DRAIN or HALT. It is also 0 combinationally in RUN in the same cycle a halting SYSTEM is accepted. Otherwise it is 1.
- flush_i in the same cycle as a SYSTEM decode: the SYSTEM is squashed, no halt, pc_wr_en_o stays 1.
- A stalled SYSTEM is not accepted; the halt begins when the stall releases.
- Reset asserted mid-DRAIN or in HALT: immediate return to RUN with outputs at reset values.
- The counter width is derived internally from DRAIN_CYCLES (4 bits is sufficient).

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (superset of defines.v, adding FENCE)
  - ALU_OP encodings
  - FSM state encoding (RUN=0, DRAIN=1, HALT=2)
  - control-bundle field ordering
- One sub-module, ctrl_decode: combinational, opcode -> bundle plus legal flag. The top module holds the ID/EX registers, the FSM and the counter.

Test Plan:
- Reset then accept R (01100), LOAD (00000), JAL (11011) back-to-back -> ex_* one cycle later: alu 10/reg_wr; mem_rd/mem_to_reg/b_sel/reg_wr; jump/pc_to_reg/a_sel/b_sel/reg_wr. ex_valid_o=1 each cycle.
- LOAD accepted, then stall_i=1 for 2 cycles while BRANCH is presented -> LOAD bundle held 2 cycles, BRANCH appears in the cycle after the stall drops. Then flush_i=1 together with stall_i=1 -> bubble the next cycle.
- SYSTEM (sys_ebreak_i=0), SYS_MODE=0, DRAIN_CYCLES=3 -> pc_wr_en_o=0 in the accept cycle, 3 DRAIN cycles, halted_o=1. resume_i pulse -> RUN, pc_wr_en_o=1.
- SYS_MODE=1: ECALL -> valid NOP, no halt. EBREAK -> halt. A stall_i pulse during DRAIN extends DRAIN by 1 cycle.
- Opcode 11111 accepted -> bubble, illegal_o pulses 1 cycle, illegal_seen_o=1 persists through later legal instructions until rst_i.
- SYSTEM presented with flush_i=1 -> no state change. rst_i asserted during HALT -> halted_o=0 asynchronously, all ex_* = 0.
